// File: rtl/target_cell_controller.sv
// target_cell_controller: places a target in one cell of a 4x4 VGA grid,
// runs its show / hit / miss lifetime, keeps saturating score and miss
// counters and produces a registered 3-bit {R,G,B} pixel colour.
// Optional build macro GRID_LINES_EN draws white grid lines outside the target.

module target_cell_controller #(
    parameter int SAMPLE_AT    = 4,
    parameter int LIFE_TICKS   = 3,
    parameter int FLASH_CYCLES = 25000000,
    parameter int CELL_W       = 160,
    parameter int CELL_H       = 120
) (
    input  logic        CLK,
    input  logic        reset,
    input  logic [27:0] nanos_in,
    input  logic [3:0]  rand_in,
    input  logic        hit_valid,
    input  logic [3:0]  hit_cell,
    input  logic [9:0]  pixel_x,
    input  logic [9:0]  pixel_y,
    input  logic        video_on,
    output logic [3:0]  target_cell,
    output logic        target_active,
    output logic [7:0]  score,
    output logic [7:0]  miss_count,
    output logic [2:0]  rgb
);

    localparam int FLASH_W = (FLASH_CYCLES > 1) ? $clog2(FLASH_CYCLES) : 1;
    localparam logic [FLASH_W-1:0] FLASH_LAST = FLASH_W'(FLASH_CYCLES - 1);

    localparam logic [9:0] X1 = 10'(CELL_W);
    localparam logic [9:0] X2 = 10'(2 * CELL_W);
    localparam logic [9:0] X3 = 10'(3 * CELL_W);
    localparam logic [9:0] X4 = 10'(4 * CELL_W);
    localparam logic [9:0] Y1 = 10'(CELL_H);
    localparam logic [9:0] Y2 = 10'(2 * CELL_H);
    localparam logic [9:0] Y3 = 10'(3 * CELL_H);
    localparam logic [9:0] Y4 = 10'(4 * CELL_H);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHOW,
        ST_HIT_FLASH,
        ST_MISS_FLASH
    } state_t;

    state_t               state_q, state_d;
    logic [3:0]           target_cell_q, target_cell_d;
    logic [3:0]           last_cell_q, last_cell_d;
    logic [3:0]           life_q, life_d;
    logic [FLASH_W-1:0]   flash_cnt_q, flash_cnt_d;
    logic [7:0]           score_q, score_d;
    logic [7:0]           miss_q, miss_d;
    logic                 active_q, active_d;
    logic [2:0]           rgb_q, rgb_d;

    logic                 tick;
    logic [3:0]           new_cell;
    logic [1:0]           col;
    logic [1:0]           row;
    logic [3:0]           px_cell;
    logic                 in_grid;
    logic                 on_grid_line;

    // Sample pulse: the upstream counter passes SAMPLE_AT exactly once per period.
    assign tick = (nanos_in == 28'(SAMPLE_AT));

    // Next-state logic for the target lifetime and the score / miss counters.
    always_comb begin
        state_d       = state_q;
        target_cell_d = target_cell_q;
        last_cell_d   = last_cell_q;
        life_d        = life_q;
        flash_cnt_d   = flash_cnt_q;
        score_d       = score_q;
        miss_d        = miss_q;
        new_cell      = (rand_in == last_cell_q) ? rand_in + 4'd1 : rand_in;

        case (state_q)
            ST_IDLE: begin
                if (tick) begin
                    target_cell_d = new_cell;
                    last_cell_d   = new_cell;
                    life_d        = 4'(LIFE_TICKS);
                    state_d       = ST_SHOW;
                end
            end
            ST_SHOW: begin
                if (hit_valid && (hit_cell == target_cell_q)) begin
                    if (score_q != 8'hFF) begin
                        score_d = score_q + 8'd1;
                    end
                    flash_cnt_d = '0;
                    state_d     = ST_HIT_FLASH;
                end else if (tick) begin
                    if (life_q == 4'd1) begin
                        if (miss_q != 8'hFF) begin
                            miss_d = miss_q + 8'd1;
                        end
                        flash_cnt_d = '0;
                        state_d     = ST_MISS_FLASH;
                    end else begin
                        life_d = life_q - 4'd1;
                    end
                end
            end
            ST_HIT_FLASH, ST_MISS_FLASH: begin
                flash_cnt_d = flash_cnt_q + 1'b1;
                if (flash_cnt_q == FLASH_LAST) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        active_d = (state_d == ST_SHOW);
    end

    // Map the current pixel onto the 4x4 grid with comparison chains instead of dividers.
    always_comb begin
        if (pixel_x < X1)      col = 2'd0;
        else if (pixel_x < X2) col = 2'd1;
        else if (pixel_x < X3) col = 2'd2;
        else                   col = 2'd3;

        if (pixel_y < Y1)      row = 2'd0;
        else if (pixel_y < Y2) row = 2'd1;
        else if (pixel_y < Y3) row = 2'd2;
        else                   row = 2'd3;

        px_cell = {row, col};
        in_grid = (pixel_x < X4) && (pixel_y < Y4);
    end

`ifdef GRID_LINES_EN
    localparam int XM_W = $clog2(CELL_W);
    localparam int YM_W = $clog2(CELL_H);
    localparam logic [XM_W-1:0] XM_LAST = XM_W'(CELL_W - 1);
    localparam logic [YM_W-1:0] YM_LAST = YM_W'(CELL_H - 1);

    logic [9:0]      prev_x_q;
    logic [9:0]      prev_y_q;
    logic [XM_W-1:0] x_mod_q, x_mod_d;
    logic [YM_W-1:0] y_mod_q, y_mod_d;

    // Track pixel_x % CELL_W and pixel_y % CELL_H by counting scan steps from the line / frame start.
    always_comb begin
        x_mod_d = x_mod_q;
        y_mod_d = y_mod_q;
        if (pixel_x == 10'd0) begin
            x_mod_d = '0;
        end else if (pixel_x != prev_x_q) begin
            x_mod_d = (x_mod_q == XM_LAST) ? '0 : x_mod_q + 1'b1;
        end
        if (pixel_y == 10'd0) begin
            y_mod_d = '0;
        end else if (pixel_y != prev_y_q) begin
            y_mod_d = (y_mod_q == YM_LAST) ? '0 : y_mod_q + 1'b1;
        end
    end

    // Remember the previous scan position and the running remainders.
    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            prev_x_q <= '0;
            prev_y_q <= '0;
            x_mod_q  <= '0;
            y_mod_q  <= '0;
        end else begin
            prev_x_q <= pixel_x;
            prev_y_q <= pixel_y;
            x_mod_q  <= x_mod_d;
            y_mod_q  <= y_mod_d;
        end
    end

    assign on_grid_line = in_grid && ((x_mod_d == '0) || (y_mod_d == '0));
`else
    assign on_grid_line = 1'b0;
`endif

    // Pixel colour: blanking first, then the target cell coloured by state, then grid lines.
    always_comb begin
        rgb_d = 3'b000;
        if (video_on) begin
            if (in_grid && (px_cell == target_cell_q)) begin
                case (state_q)
                    ST_SHOW:       rgb_d = 3'b100;
                    ST_HIT_FLASH:  rgb_d = 3'b010;
                    ST_MISS_FLASH: rgb_d = 3'b001;
                    default:       rgb_d = 3'b000;
                endcase
            end else if (on_grid_line) begin
                rgb_d = 3'b111;
            end
        end
    end

    // State register and registered outputs.
    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            state_q       <= ST_IDLE;
            target_cell_q <= '0;
            last_cell_q   <= '0;
            life_q        <= '0;
            flash_cnt_q   <= '0;
            score_q       <= '0;
            miss_q        <= '0;
            active_q      <= 1'b0;
            rgb_q         <= 3'b000;
        end else begin
            state_q       <= state_d;
            target_cell_q <= target_cell_d;
            last_cell_q   <= last_cell_d;
            life_q        <= life_d;
            flash_cnt_q   <= flash_cnt_d;
            score_q       <= score_d;
            miss_q        <= miss_d;
            active_q      <= active_d;
            rgb_q         <= rgb_d;
        end
    end

    assign target_cell   = target_cell_q;
    assign target_active = active_q;
    assign score         = score_q;
    assign miss_count    = miss_q;
    assign rgb           = rgb_q;

endmodule

// File: tb/tb_target_cell_controller.sv
// Directed testbench for target_cell_controller with a short flash length.
// Expected colour at a grid-line pixel depends on the GRID_LINES_EN macro.

module tb_target_cell_controller;

    localparam int SAMPLE_AT = 4;
    localparam int FC        = 4;

    logic        CLK;
    logic        reset;
    logic [27:0] nanos_in;
    logic [3:0]  rand_in;
    logic        hit_valid;
    logic [3:0]  hit_cell;
    logic [9:0]  pixel_x;
    logic [9:0]  pixel_y;
    logic        video_on;
    logic [3:0]  target_cell;
    logic        target_active;
    logic [7:0]  score;
    logic [7:0]  miss_count;
    logic [2:0]  rgb;

    int          n_checks;
    int          n_fail;
    logic [7:0]  exp_score;
    logic [7:0]  exp_miss;
    logic [3:0]  last;

    target_cell_controller #(
        .SAMPLE_AT    (SAMPLE_AT),
        .LIFE_TICKS   (3),
        .FLASH_CYCLES (FC),
        .CELL_W       (160),
        .CELL_H       (120)
    ) dut (
        .CLK           (CLK),
        .reset         (reset),
        .nanos_in      (nanos_in),
        .rand_in       (rand_in),
        .hit_valid     (hit_valid),
        .hit_cell      (hit_cell),
        .pixel_x       (pixel_x),
        .pixel_y       (pixel_y),
        .video_on      (video_on),
        .target_cell   (target_cell),
        .target_active (target_active),
        .score         (score),
        .miss_count    (miss_count),
        .rgb           (rgb)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [3:0] next_cell(input logic [3:0] r, input logic [3:0] prev);
        return (r == prev) ? r + 4'd1 : r;
    endfunction

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_tick(input logic [3:0] r);
        rand_in  = r;
        nanos_in = 28'(SAMPLE_AT);
        step();
        nanos_in = 28'd0;
    endtask

    task automatic do_hit(input logic [3:0] c);
        hit_valid = 1'b1;
        hit_cell  = c;
        step();
        hit_valid = 1'b0;
    endtask

    task automatic finish_flash();
        repeat (FC) step();
    endtask

    task automatic sweep_to(input logic [9:0] x, input logic [9:0] y);
        pixel_x = 10'd0;
        for (int yy = 0; yy <= int'(y); yy++) begin
            pixel_y = 10'(yy);
            step();
        end
        for (int xx = 0; xx <= int'(x); xx++) begin
            pixel_x = 10'(xx);
            step();
        end
    endtask

    task automatic test_reset();
        reset     = 1'b1;
        nanos_in  = 28'd0;
        rand_in   = 4'd0;
        hit_valid = 1'b0;
        hit_cell  = 4'd0;
        pixel_x   = 10'd0;
        pixel_y   = 10'd0;
        video_on  = 1'b0;
        #2 reset = 1'b0;
        repeat (3) step();
        n_checks++; if (target_cell !== 4'd0) begin n_fail++; $display("FAIL reset_cell: got %0d expected 0", target_cell); end
        n_checks++; if (target_active !== 1'b0) begin n_fail++; $display("FAIL reset_active: got %b expected 0", target_active); end
        n_checks++; if (score !== 8'd0) begin n_fail++; $display("FAIL reset_score: got %0d expected 0", score); end
        n_checks++; if (miss_count !== 8'd0) begin n_fail++; $display("FAIL reset_miss: got %0d expected 0", miss_count); end
        n_checks++; if (rgb !== 3'b000) begin n_fail++; $display("FAIL reset_rgb: got %b expected 000", rgb); end
        reset     = 1'b1;
        exp_score = 8'd0;
        exp_miss  = 8'd0;
        last      = 4'd0;
        step();
    endtask

    task automatic test_first_target();
        rand_in = 4'd6;
        for (int n = 0; n <= 10; n++) begin
            nanos_in = 28'(n);
            step();
            if (n == 3) begin
                n_checks++; if (target_active !== 1'b0) begin n_fail++; $display("FAIL early_active: got %b expected 0", target_active); end
            end
            if (n == 4) begin
                n_checks++; if (target_cell !== 4'd6) begin n_fail++; $display("FAIL first_cell: got %0d expected 6", target_cell); end
                n_checks++; if (target_active !== 1'b1) begin n_fail++; $display("FAIL first_active: got %b expected 1", target_active); end
            end
        end
        nanos_in = 28'd0;
        last = 4'd6;
        do_hit(4'd6);
        exp_score = 8'd1;
        n_checks++; if (score !== exp_score) begin n_fail++; $display("FAIL first_score: got %0d expected %0d", score, exp_score); end
        finish_flash();
    endtask

    task automatic test_repeat_cell();
        logic [3:0] r_tab [3];
        logic [3:0] e_tab [3];
        r_tab[0] = 4'd6;  e_tab[0] = 4'd7;
        r_tab[1] = 4'd15; e_tab[1] = 4'd15;
        r_tab[2] = 4'd15; e_tab[2] = 4'd0;
        for (int i = 0; i < 3; i++) begin
            do_tick(r_tab[i]);
            n_checks++; if (target_cell !== e_tab[i]) begin n_fail++; $display("FAIL repeat_cell[%0d]: got %0d expected %0d", i, target_cell, e_tab[i]); end
            last = e_tab[i];
            do_hit(e_tab[i]);
            exp_score++;
            finish_flash();
        end
        n_checks++; if (score !== 8'd4) begin n_fail++; $display("FAIL repeat_score: got %0d expected 4", score); end
    endtask

    task automatic test_hit_flash();
        pixel_x  = 10'd170;
        pixel_y  = 10'd250;
        video_on = 1'b1;
        do_tick(4'd9);
        last = 4'd9;
        n_checks++; if (target_cell !== 4'd9) begin n_fail++; $display("FAIL hit_cell_load: got %0d expected 9", target_cell); end
        step();
        n_checks++; if (rgb !== 3'b100) begin n_fail++; $display("FAIL show_rgb: got %b expected 100", rgb); end
        do_hit(4'd3);
        n_checks++; if (score !== exp_score) begin n_fail++; $display("FAIL wrong_hit_score: got %0d expected %0d", score, exp_score); end
        n_checks++; if (target_active !== 1'b1) begin n_fail++; $display("FAIL wrong_hit_active: got %b expected 1", target_active); end
        do_hit(4'd9);
        exp_score++;
        n_checks++; if (score !== exp_score) begin n_fail++; $display("FAIL hit_score: got %0d expected %0d", score, exp_score); end
        n_checks++; if (target_active !== 1'b0) begin n_fail++; $display("FAIL hit_active: got %b expected 0", target_active); end
        step();
        n_checks++; if (rgb !== 3'b010) begin n_fail++; $display("FAIL hit_rgb: got %b expected 010", rgb); end
        repeat (FC - 2) step();
        step();
        n_checks++; if (rgb !== 3'b010) begin n_fail++; $display("FAIL hit_flash_last: got %b expected 010", rgb); end
        step();
        n_checks++; if (rgb !== 3'b000) begin n_fail++; $display("FAIL hit_flash_end: got %b expected 000", rgb); end
    endtask

    task automatic test_miss();
        pixel_x = 10'd330;
        pixel_y = 10'd10;
        do_tick(4'd2);
        last = 4'd2;
        step();
        n_checks++; if (rgb !== 3'b100) begin n_fail++; $display("FAIL miss_show_rgb: got %b expected 100", rgb); end
        do_tick(4'd2);
        step();
        step();
        do_tick(4'd2);
        n_checks++; if (target_active !== 1'b1) begin n_fail++; $display("FAIL miss_still_active: got %b expected 1", target_active); end
        n_checks++; if (miss_count !== 8'd0) begin n_fail++; $display("FAIL miss_early: got %0d expected 0", miss_count); end
        do_tick(4'd2);
        exp_miss = 8'd1;
        n_checks++; if (miss_count !== exp_miss) begin n_fail++; $display("FAIL miss_count: got %0d expected %0d", miss_count, exp_miss); end
        n_checks++; if (target_active !== 1'b0) begin n_fail++; $display("FAIL miss_active: got %b expected 0", target_active); end
        n_checks++; if (score !== exp_score) begin n_fail++; $display("FAIL miss_score: got %0d expected %0d", score, exp_score); end
        step();
        n_checks++; if (rgb !== 3'b001) begin n_fail++; $display("FAIL miss_rgb: got %b expected 001", rgb); end
        repeat (FC - 1) step();
    endtask

    task automatic test_hit_on_expiry();
        video_on = 1'b0;
        do_tick(4'd5);
        last = 4'd5;
        do_tick(4'd5);
        do_tick(4'd5);
        rand_in   = 4'd5;
        nanos_in  = 28'(SAMPLE_AT);
        hit_valid = 1'b1;
        hit_cell  = 4'd5;
        step();
        nanos_in  = 28'd0;
        hit_valid = 1'b0;
        exp_score++;
        n_checks++; if (score !== exp_score) begin n_fail++; $display("FAIL expiry_score: got %0d expected %0d", score, exp_score); end
        n_checks++; if (miss_count !== exp_miss) begin n_fail++; $display("FAIL expiry_miss: got %0d expected %0d", miss_count, exp_miss); end
        do_hit(4'd5);
        do_tick(4'd3);
        step();
        do_tick(4'd11);
        n_checks++; if (score !== exp_score) begin n_fail++; $display("FAIL flash_hit_ignored: got %0d expected %0d", score, exp_score); end
        n_checks++; if (target_active !== 1'b0) begin n_fail++; $display("FAIL exit_tick_active: got %b expected 0", target_active); end
        n_checks++; if (target_cell !== 4'd5) begin n_fail++; $display("FAIL exit_tick_cell: got %0d expected 5", target_cell); end
        step();
        n_checks++; if (target_active !== 1'b0) begin n_fail++; $display("FAIL idle_hold: got %b expected 0", target_active); end
        do_tick(4'd11);
        last = 4'd11;
        n_checks++; if (target_cell !== 4'd11) begin n_fail++; $display("FAIL after_exit_cell: got %0d expected 11", target_cell); end
        do_hit(4'd11);
        exp_score++;
        finish_flash();
    endtask

    task automatic test_saturation();
        logic [3:0] r;
        logic [3:0] c;
        for (int k = 0; k < 255; k++) begin
            r = 4'(k);
            c = next_cell(r, last);
            last = c;
            do_tick(r);
            n_checks++; if (target_cell !== c) begin n_fail++; $display("FAIL sat_cell[%0d]: got %0d expected %0d", k, target_cell, c); end
            do_hit(c);
            if (exp_score != 8'hFF) exp_score++;
            finish_flash();
        end
        n_checks++; if (score !== 8'd255) begin n_fail++; $display("FAIL score_sat: got %0d expected 255", score); end
        n_checks++; if (score !== exp_score) begin n_fail++; $display("FAIL score_model: got %0d expected %0d", score, exp_score); end
        n_checks++; if (miss_count !== exp_miss) begin n_fail++; $display("FAIL sat_miss: got %0d expected %0d", miss_count, exp_miss); end
    endtask

    task automatic test_async_reset();
        logic [3:0] c;
        c = next_cell(4'd14, last);
        pixel_x  = 10'(160 * int'(c[1:0]) + 5);
        pixel_y  = 10'(120 * int'(c[3:2]) + 5);
        video_on = 1'b1;
        do_tick(4'd14);
        step();
        n_checks++; if (rgb !== 3'b100) begin n_fail++; $display("FAIL pre_reset_rgb: got %b expected 100", rgb); end
        #2 reset = 1'b0;
        #1;
        n_checks++; if (target_cell !== 4'd0) begin n_fail++; $display("FAIL areset_cell: got %0d expected 0", target_cell); end
        n_checks++; if (target_active !== 1'b0) begin n_fail++; $display("FAIL areset_active: got %b expected 0", target_active); end
        n_checks++; if (score !== 8'd0) begin n_fail++; $display("FAIL areset_score: got %0d expected 0", score); end
        n_checks++; if (miss_count !== 8'd0) begin n_fail++; $display("FAIL areset_miss: got %0d expected 0", miss_count); end
        n_checks++; if (rgb !== 3'b000) begin n_fail++; $display("FAIL areset_rgb: got %b expected 000", rgb); end
        step();
        reset = 1'b1;
        exp_score = 8'd0;
        exp_miss  = 8'd0;
        step();
        step();
        n_checks++; if (target_active !== 1'b0) begin n_fail++; $display("FAIL post_reset_idle: got %b expected 0", target_active); end
        do_tick(4'd0);
        last = 4'd1;
        n_checks++; if (target_cell !== 4'd1) begin n_fail++; $display("FAIL post_reset_last: got %0d expected 1", target_cell); end
        do_hit(4'd1);
        finish_flash();
    endtask

    task automatic test_video();
        logic [2:0] exp_line;
`ifdef GRID_LINES_EN
        exp_line = 3'b111;
`else
        exp_line = 3'b000;
`endif
        do_tick(4'd12);
        last = 4'd12;
        pixel_x  = 10'd10;
        pixel_y  = 10'd400;
        video_on = 1'b0;
        step();
        n_checks++; if (rgb !== 3'b000) begin n_fail++; $display("FAIL video_off: got %b expected 000", rgb); end
        video_on = 1'b1;
        step();
        n_checks++; if (rgb !== 3'b100) begin n_fail++; $display("FAIL video_on_target: got %b expected 100", rgb); end
        sweep_to(10'd160, 10'd50);
        n_checks++; if (rgb !== exp_line) begin n_fail++; $display("FAIL grid_line: got %b expected %b", rgb, exp_line); end
        sweep_to(10'd200, 10'd50);
        n_checks++; if (rgb !== 3'b000) begin n_fail++; $display("FAIL grid_interior: got %b expected 000", rgb); end
        sweep_to(10'd640, 10'd0);
        n_checks++; if (rgb !== 3'b000) begin n_fail++; $display("FAIL outside_grid: got %b expected 000", rgb); end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_first_target();
        test_repeat_cell();
        test_hit_flash();
        test_miss();
        test_hit_on_expiry();
        test_saturation();
        test_async_reset();
        test_video();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
